// File: rtl/buffet_fill_producer.sv
// Credit-consuming producer on a buffet fill port: streams cmd_len upstream
// words into the buffet, never exceeding the last sampled free-slot snapshot.
module buffet_fill_producer #(
    parameter int IDX_WIDTH     = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int SIZE          = 128,
    parameter int LEN_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_data_valid,
    input  logic                  push_data_ready,
    input  logic [IDX_WIDTH-1:0]  credit_in,
    input  logic                  credit_valid,
    output logic                  credit_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  credit_err
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0]       SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] SIZE_C      = IDX_WIDTH'(SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_PUSH,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   remain_q, remain_d;
    logic [IDX_WIDTH-1:0]   credits_q, credits_d;
    logic [SCW-1:0]         settle_cnt_q, settle_cnt_d;
    logic                   credit_err_q, credit_err_d;

    logic                   has_work;
    logic                   fire;

    // Zero-latency pass-through: the buffet sees upstream data directly,
    // gated only by the credit and length budget.
    always_comb begin
        has_work        = (credits_q != '0) && (remain_q != '0);
        push_data       = in_data;
        push_data_valid = (state_q == S_PUSH) && in_valid && has_work;
        in_ready        = (state_q == S_PUSH) && push_data_ready && has_work;
        fire            = push_data_valid && push_data_ready;
    end

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        credits_d    = credits_q;
        settle_cnt_d = settle_cnt_q;
        credit_err_d = credit_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    remain_d = cmd_len;
                    state_d  = (cmd_len == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (credit_valid) begin
                    if (credit_in > SIZE_C) begin
                        credits_d    = SIZE_C;
                        credit_err_d = 1'b1;
                    end else begin
                        credits_d = credit_in;
                    end
                    if (credit_in == '0) begin
                        state_d      = S_SETTLE;
                        settle_cnt_d = '0;
                    end else begin
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                if (fire) begin
                    remain_d  = remain_q - LEN_WIDTH'(1);
                    credits_d = credits_q - IDX_WIDTH'(1);
                    // Finishing the command wins over running out of credit.
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end else if (credits_q == IDX_WIDTH'(1)) begin
                        state_d      = S_SETTLE;
                        settle_cnt_d = '0;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_REQ;
                end else begin
                    settle_cnt_d = settle_cnt_q + SCW'(1);
                end
            end
            S_DONE: begin
                credits_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            remain_q     <= '0;
            credits_q    <= '0;
            settle_cnt_q <= '0;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            credits_q    <= credits_d;
            settle_cnt_q <= settle_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    always_comb begin
        cmd_ready    = (state_q == S_IDLE);
        credit_ready = (state_q == S_REQ);
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        credit_err   = credit_err_q;
    end

endmodule
